// File: rtl/hex_key_avs_responder.sv
// hex_key_avs_responder: Avalon-MM responder driving six active-low 7-segment
// displays and capturing pushbutton state and press edges with a level irq.
// Optional build macro HEX_LEADING_ZERO_BLANK_EN blanks leading zero digits in
// decode mode (HEX0 always shows at least "0").
module hex_key_avs_responder #(
  parameter int          RD_LAT    = 1,
  parameter int          BLINK_DIV = 25000000,
  parameter logic [31:0] ID_VAL    = 32'h4845_5831
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        avs_waitrequest,
  input  logic [3:0]  key_n,
  output logic        irq,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic        r_waitReq;
  logic        w_rdAcc;
  logic        w_wrAcc;
  logic [31:0] w_beMask;
  logic [31:0] w_rdMux;
  logic [7:0]  w_unused;

  logic [23:0] r_digits;
  logic [5:0]  r_digEn;
  logic        r_rawMode;
  logic        r_blinkEn;
  logic [27:0] r_rawLo;
  logic [13:0] r_rawHi;
  logic [3:0]  r_irqMask;
  logic [3:0]  r_keyEdge;

  logic [3:0]  r_keyMeta;
  logic [3:0]  r_keySync;
  logic [3:0]  r_keyPrev;
  logic [3:0]  w_keyPress;
  logic [3:0]  w_edgeClr;
  logic        r_irq;

  logic [RD_LAT-1:0] r_pipeValid;
  logic [31:0]       r_pipeData [RD_LAT];

  logic [CW-1:0] r_blinkCnt;
  logic          r_phase;

  logic [41:0] w_rawAll;
  logic [5:0]  w_blankLz;
  logic [6:0]  r_hex [6];

  // Active-low glyphs for 0-F, bit 0 = segment a
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  assign w_rdAcc  = avs_read & ~avs_write & ~r_waitReq;
  assign w_wrAcc  = avs_write & ~r_waitReq;
  assign w_beMask = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                     {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
  assign w_unused = {avs_writedata[31:28], w_beMask[31:28]};

  assign avs_waitrequest   = r_waitReq;
  assign avs_readdatavalid = r_pipeValid[RD_LAT-1];
  assign avs_readdata      = r_pipeData[RD_LAT-1];
  assign irq               = r_irq;

  assign hex0 = r_hex[0];
  assign hex1 = r_hex[1];
  assign hex2 = r_hex[2];
  assign hex3 = r_hex[3];
  assign hex4 = r_hex[4];
  assign hex5 = r_hex[5];

  // Stall the bus through reset and for one cycle after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_waitReq <= 1'b1;
    else        r_waitReq <= 1'b0;
  end

  // Byte-lane masked writes to the writable configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits  <= '0;
      r_digEn   <= 6'h3F;
      r_rawMode <= 1'b0;
      r_blinkEn <= 1'b0;
      r_rawLo   <= '1;
      r_rawHi   <= '1;
      r_irqMask <= '0;
    end else if (w_wrAcc) begin
      case (avs_address)
        3'd0: r_digits <= (r_digits & ~w_beMask[23:0]) | (avs_writedata[23:0] & w_beMask[23:0]);
        3'd1: begin
          if (avs_byteenable[0]) r_digEn <= avs_writedata[5:0];
          if (avs_byteenable[1]) begin
            r_rawMode <= avs_writedata[8];
            r_blinkEn <= avs_writedata[9];
          end
        end
        3'd2: r_rawLo <= (r_rawLo & ~w_beMask[27:0]) | (avs_writedata[27:0] & w_beMask[27:0]);
        3'd3: r_rawHi <= (r_rawHi & ~w_beMask[13:0]) | (avs_writedata[13:0] & w_beMask[13:0]);
        3'd6: if (avs_byteenable[0]) r_irqMask <= avs_writedata[3:0];
        default: ;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous keys plus a previous-value stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_keyMeta <= 4'hF;
      r_keySync <= 4'hF;
      r_keyPrev <= 4'hF;
    end else begin
      r_keyMeta <= key_n;
      r_keySync <= r_keyMeta;
      r_keyPrev <= r_keySync;
    end
  end

  assign w_keyPress = r_keyPrev & ~r_keySync;
  assign w_edgeClr  = (w_wrAcc && avs_address == 3'd5 && avs_byteenable[0]) ?
                      avs_writedata[3:0] : 4'h0;

  // Sticky press edges; a new edge overrides a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_keyEdge <= '0;
    else        r_keyEdge <= (r_keyEdge & ~w_edgeClr) | w_keyPress;
  end

  // Registered level interrupt from masked edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= |(r_keyEdge & r_irqMask);
  end

  // Read data selected from register state at the moment of acceptance
  always_comb begin
    w_rdMux = 32'h0;
    case (avs_address)
      3'd0: w_rdMux = {8'h0, r_digits};
      3'd1: w_rdMux = {22'h0, r_blinkEn, r_rawMode, 2'b00, r_digEn};
      3'd2: w_rdMux = {4'h0, r_rawLo};
      3'd3: w_rdMux = {18'h0, r_rawHi};
      3'd4: w_rdMux = {28'h0, ~r_keySync};
      3'd5: w_rdMux = {28'h0, r_keyEdge};
      3'd6: w_rdMux = {28'h0, r_irqMask};
      default: w_rdMux = ID_VAL;
    endcase
  end

  // Fixed-latency read pipeline; data stages only load behind a valid so the
  // output holds its last value between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipeValid <= '0;
      for (int i = 0; i < RD_LAT; i++) r_pipeData[i] <= '0;
    end else begin
      r_pipeValid[0] <= w_rdAcc;
      if (w_rdAcc) r_pipeData[0] <= w_rdMux;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        if (r_pipeValid[i-1]) r_pipeData[i] <= r_pipeData[i-1];
      end
    end
  end

  // Blink timebase; held at zero phase while blinking is off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blinkCnt <= '0;
      r_phase    <= 1'b0;
    end else if (!r_blinkEn) begin
      r_blinkCnt <= '0;
      r_phase    <= 1'b0;
    end else if (r_blinkCnt == CW'(BLINK_DIV - 1)) begin
      r_blinkCnt <= '0;
      r_phase    <= ~r_phase;
    end else begin
      r_blinkCnt <= r_blinkCnt + 1'b1;
    end
  end

  assign w_rawAll = {r_rawHi, r_rawLo};

  // Leading-zero suppression mask, scanning from the most significant digit
  always_comb begin
    w_blankLz = '0;
`ifdef HEX_LEADING_ZERO_BLANK_EN
    begin
      logic nzSeen;
      nzSeen = 1'b0;
      for (int i = 5; i >= 1; i--) begin
        if (r_digEn[i] && r_digits[4*i +: 4] == 4'h0 && !nzSeen) w_blankLz[i] = 1'b1;
        if (r_digEn[i] && r_digits[4*i +: 4] != 4'h0) nzSeen = 1'b1;
      end
    end
`endif
  end

  // Registered display outputs: blink and disable blank, else raw or decoded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) r_hex[i] <= 7'h7F;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if ((r_blinkEn && r_phase) || !r_digEn[i]) r_hex[i] <= 7'h7F;
        else if (r_rawMode)                        r_hex[i] <= w_rawAll[7*i +: 7];
        else if (w_blankLz[i])                     r_hex[i] <= 7'h7F;
        else                                       r_hex[i] <= seg7(r_digits[4*i +: 4]);
      end
    end
  end

endmodule

// File: tb/tb_hex_key_avs_responder.sv
// Self-checking bench for hex_key_avs_responder (RD_LAT=3, BLINK_DIV=4).
module tb_hex_key_avs_responder;

  localparam int          RD_LAT    = 3;
  localparam int          BLINK_DIV = 4;
  localparam logic [31:0] ID_VAL    = 32'h4845_5831;

  logic        clk;
  logic        rst_n;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;
  logic [3:0]  key_n;
  logic        irq;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [6:0]  hexArr [6];

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } SbEntry;

  SbEntry      sbQ [$];
  int          checks   = 0;
  int          failures = 0;
  int          cycCnt   = 0;
  logic [23:0] modelDigits;

  hex_key_avs_responder #(
    .RD_LAT   (RD_LAT),
    .BLINK_DIV(BLINK_DIV),
    .ID_VAL   (ID_VAL)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .avs_address      (avs_address),
    .avs_read         (avs_read),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_byteenable   (avs_byteenable),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest  (avs_waitrequest),
    .key_n            (key_n),
    .irq              (irq),
    .hex0             (hex0),
    .hex1             (hex1),
    .hex2             (hex2),
    .hex3             (hex3),
    .hex4             (hex4),
    .hex5             (hex5)
  );

  assign hexArr[0] = hex0;
  assign hexArr[1] = hex1;
  assign hexArr[2] = hex2;
  assign hexArr[3] = hex3;
  assign hexArr[4] = hex4;
  assign hexArr[5] = hex5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycCnt <= cycCnt + 1;

  // Counts one comparison and reports it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] expSeg(input logic [3:0] v);
    case (v)
      4'h0: expSeg = 7'h40;  4'h1: expSeg = 7'h79;
      4'h2: expSeg = 7'h24;  4'h3: expSeg = 7'h30;
      4'h4: expSeg = 7'h19;  4'h5: expSeg = 7'h12;
      4'h6: expSeg = 7'h02;  4'h7: expSeg = 7'h78;
      4'h8: expSeg = 7'h00;  4'h9: expSeg = 7'h10;
      4'hA: expSeg = 7'h08;  4'hB: expSeg = 7'h03;
      4'hC: expSeg = 7'h46;  4'hD: expSeg = 7'h21;
      4'hE: expSeg = 7'h06;  default: expSeg = 7'h0E;
    endcase
  endfunction

  // Expected glyph for digit idx with all digits enabled, decode mode
  function automatic logic [6:0] expDigitHex(input logic [23:0] d, input int idx);
    logic [3:0]  nib;
    logic [23:0] above;
    nib   = d[idx*4 +: 4];
    above = d >> (4 * (idx + 1));
    expDigitHex = expSeg(nib);
`ifdef HEX_LEADING_ZERO_BLANK_EN
    if (idx > 0 && nib == 4'h0 && above == 24'h0) expDigitHex = 7'h7F;
`else
    if (above == 24'hFFFFFF) expDigitHex = 7'h7F;
`endif
  endfunction

  // Pops and compares each read response against the scoreboard
  always @(negedge clk) begin : monitorBlk
    SbEntry e;
    if (avs_readdatavalid === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("rdata", avs_readdata, e.data);
        checkOutput("rlat", 32'(cycCnt - e.cyc), 32'(RD_LAT));
      end
    end
  end

  // Drives one bus cycle; a plain read pushes its expected response
  task automatic applyStimulus(input logic isWrite, input logic isRead, input logic [2:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic [31:0] expRd);
    @(negedge clk);
    avs_address    = addr;
    avs_write      = isWrite;
    avs_read       = isRead;
    avs_writedata  = wdata;
    avs_byteenable = be;
    if (isRead && !isWrite) sbQ.push_back('{expRd, cycCnt});
    @(posedge clk);
    #1;
    avs_write = 1'b0;
    avs_read  = 1'b0;
  endtask

  task automatic checkResetState();
    for (int i = 0; i < 6; i++) checkOutput($sformatf("rst_hex%0d", i), 32'(hexArr[i]), 32'h7F);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_wait", 32'(avs_waitrequest), 32'd1);
    checkOutput("rst_rvalid", 32'(avs_readdatavalid), 32'd0);
    checkOutput("rst_rdata", avs_readdata, 32'd0);
  endtask

  task automatic checkDecoded(input string tag);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("%s_hex%0d", tag, i), 32'(hexArr[i]), 32'(expDigitHex(modelDigits, i)));
  endtask

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL timeout checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n          = 1'b0;
    avs_address    = '0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_writedata  = '0;
    avs_byteenable = '0;
    key_n          = 4'hF;
    modelDigits    = '0;

    repeat (3) @(negedge clk);
    checkResetState();

    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("wait_after_release", 32'(avs_waitrequest), 32'd1);
    @(posedge clk);
    #1 checkOutput("wait_cleared", 32'(avs_waitrequest), 32'd0);

    $display("[TB] ID read at first ready cycle");
    applyStimulus(1'b0, 1'b1, 3'd7, 32'h0, 4'h0, ID_VAL);
    repeat (RD_LAT + 2) @(negedge clk);
    checkOutput("id_pending", 32'(sbQ.size()), 32'd0);
    checkDecoded("zero");

    $display("[TB] Digit decode and byte lanes");
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h00123456, 4'hF, 32'h0);
    modelDigits = 24'h123456;
    repeat (2) @(negedge clk);
    checkDecoded("d123456");
    checkOutput("hex0_six", 32'(hex0), 32'h02);

    applyStimulus(1'b1, 1'b0, 3'd0, 32'hFFFFFFFF, 4'b0001, 32'h0);
    modelDigits = 24'h1234FF;
    applyStimulus(1'b0, 1'b1, 3'd0, 32'h0, 4'h0, 32'h001234FF);
    repeat (2) @(negedge clk);
    checkDecoded("d1234ff");

    applyStimulus(1'b1, 1'b0, 3'd0, 32'h00000050, 4'hF, 32'h0);
    modelDigits = 24'h000050;
    repeat (2) @(negedge clk);
    checkDecoded("d50");

    $display("[TB] Raw mode and digit disable");
    applyStimulus(1'b1, 1'b0, 3'd2, 32'hFABCDEF5, 4'hF, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'd3, 32'hFFFF1234, 4'hF, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'd1, 32'h0000013F, 4'hF, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("raw_hex0", 32'(hex0), 32'h75);
    checkOutput("raw_hex4", 32'(hex4), 32'h34);
    checkOutput("raw_hex5", 32'(hex5), 32'h24);
    applyStimulus(1'b0, 1'b1, 3'd2, 32'h0, 4'h0, 32'h0ABCDEF5);
    applyStimulus(1'b0, 1'b1, 3'd3, 32'h0, 4'h0, 32'h00001234);
    applyStimulus(1'b1, 1'b0, 3'd1, 32'h0000003E, 4'hF, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("dis_hex0", 32'(hex0), 32'h7F);
    checkOutput("dis_hex1", 32'(hex1), 32'h12);
    applyStimulus(1'b0, 1'b1, 3'd1, 32'h0, 4'h0, 32'h0000003E);

    $display("[TB] Simultaneous read and write");
    applyStimulus(1'b1, 1'b1, 3'd6, 32'h00000004, 4'hF, 32'h0);
    applyStimulus(1'b0, 1'b1, 3'd6, 32'h0, 4'h0, 32'h00000004);
    repeat (RD_LAT + 2) @(negedge clk);

    $display("[TB] Key press, edge and irq");
    key_n[2] = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("irq_press", 32'(irq), 32'd1);
    applyStimulus(1'b0, 1'b1, 3'd5, 32'h0, 4'h0, 32'h4);
    applyStimulus(1'b0, 1'b1, 3'd4, 32'h0, 4'h0, 32'h4);
    key_n = 4'hF;
    repeat (4) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 3'd5, 32'h4, 4'b0001, 32'h0);
    @(negedge clk);
    checkOutput("irq_hold", 32'(irq), 32'd1);
    @(negedge clk);
    checkOutput("irq_clr", 32'(irq), 32'd0);

    @(negedge clk);
    key_n[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    applyStimulus(1'b1, 1'b0, 3'd5, 32'h4, 4'b0001, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("irq_setwins", 32'(irq), 32'd1);
    applyStimulus(1'b0, 1'b1, 3'd5, 32'h0, 4'h0, 32'h4);
    applyStimulus(1'b1, 1'b0, 3'd5, 32'h4, 4'b0001, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("irq_clr2", 32'(irq), 32'd0);
    applyStimulus(1'b0, 1'b1, 3'd5, 32'h0, 4'h0, 32'h0);
    key_n = 4'hF;
    repeat (4) @(negedge clk);

    $display("[TB] Back-to-back reads");
    applyStimulus(1'b0, 1'b1, 3'd0, 32'h0, 4'h0, {8'h0, modelDigits});
    applyStimulus(1'b0, 1'b1, 3'd1, 32'h0, 4'h0, 32'h0000003E);
    applyStimulus(1'b0, 1'b1, 3'd4, 32'h0, 4'h0, 32'h0);
    repeat (RD_LAT + 2) @(negedge clk);
    checkOutput("b2b_pending", 32'(sbQ.size()), 32'd0);

    $display("[TB] Blink");
    applyStimulus(1'b1, 1'b0, 3'd1, 32'h0000023F, 4'hF, 32'h0);
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("blink_n%0d", n), 32'(hex1),
                  (n >= 5 && n <= 8) ? 32'h7F : 32'h12);
    end
    applyStimulus(1'b1, 1'b0, 3'd1, 32'h0000003F, 4'hF, 32'h0);
    repeat (2) @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checkOutput($sformatf("steady_n%0d", n), 32'(hex1), 32'h12);
    end

    $display("[TB] Reset during read stream");
    applyStimulus(1'b0, 1'b1, 3'd0, 32'h0, 4'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 3'd1, 32'h0, 4'h0, 32'h0);
    rst_n = 1'b0;
    sbQ.delete();
    repeat (3) @(negedge clk);
    checkResetState();
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 3'd7, 32'h0, 4'h0, ID_VAL);
    repeat (RD_LAT + 2) @(negedge clk);
    checkOutput("final_pending", 32'(sbQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
